// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory-port arbiter.
// Holds the fixed bus widths, the 3-bit FSM state encoding, the owner codes
// and a small helper used to classify states.
package mem_arbiter_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_DATA_W = 32;
  localparam int unsigned MEM_ARB_STRB_W = 4;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StIfReq   = 3'd1,
    StIfWait  = 3'd2,
    StMemReq  = 3'd3,
    StMemWait = 3'd4,
    StResp    = 3'd5
  } arb_state_e;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  function automatic logic is_req_state(input arb_state_e s);
    return (s == StIfReq) || (s == StMemReq);
  endfunction

  function automatic logic is_wait_state(input arb_state_e s);
    return (s == StIfWait) || (s == StMemWait);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter for the single shared memory port between the IF stage (fetch,
// read-only) and the MEM stage (loads/stores).
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_req_*                 fetch request (valid/addr in, ready out)
//   if_resp_*                one-cycle fetch response pulse and data
//   mem_req_*                load/store request (valid/wen/addr/wdata/wstrb in, ready out)
//   mem_resp_*               one-cycle load-data / store-done pulse and data
//   flush                    branch misprediction; discards a pending fetch result
//   bus_*                    memory-side request and read-data handshakes
//
// One transaction is in flight at a time. MEM has fixed priority over IF since
// it belongs to the older instruction. All bus and response outputs are
// registered; only the request ready signals are combinational.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      if_req_valid,
  input  logic [MEM_ARB_ADDR_W-1:0] if_req_addr,
  output logic                      if_req_ready,
  output logic                      if_resp_valid,
  output logic [MEM_ARB_DATA_W-1:0] if_resp_data,

  input  logic                      mem_req_valid,
  input  logic                      mem_req_wen,
  input  logic [MEM_ARB_ADDR_W-1:0] mem_req_addr,
  input  logic [MEM_ARB_DATA_W-1:0] mem_req_wdata,
  input  logic [MEM_ARB_STRB_W-1:0] mem_req_wstrb,
  output logic                      mem_req_ready,
  output logic                      mem_resp_valid,
  output logic [MEM_ARB_DATA_W-1:0] mem_resp_data,

  input  logic                      flush,

  output logic [MEM_ARB_ADDR_W-1:0] bus_addr,
  output logic                      bus_read,
  output logic                      bus_write,
  output logic [MEM_ARB_DATA_W-1:0] bus_wdata,
  output logic [MEM_ARB_STRB_W-1:0] bus_wstrb,
  input  logic                      bus_req_ready,
  input  logic [MEM_ARB_DATA_W-1:0] bus_rdata,
  input  logic                      bus_rdata_valid,
  output logic                      bus_rdata_ready
);

  arb_state_e                state_q, state_d;
  owner_e                    owner_q, owner_d;
  logic                      wen_q, wen_d;
  logic [MEM_ARB_ADDR_W-1:0] addr_q, addr_d;
  logic [MEM_ARB_DATA_W-1:0] wdata_q, wdata_d;
  logic [MEM_ARB_STRB_W-1:0] wstrb_q, wstrb_d;
  logic [MEM_ARB_DATA_W-1:0] resp_data_q, resp_data_d;
  logic                      drop_q, drop_d;

  logic bus_read_q, bus_read_d;
  logic bus_write_q, bus_write_d;
  logic bus_rdata_ready_q, bus_rdata_ready_d;
  logic if_resp_valid_q, if_resp_valid_d;
  logic mem_resp_valid_q, mem_resp_valid_d;

  logic in_idle;
  logic mem_grant;
  logic if_grant;

  // Readies are gated by rst so they read 0 while reset is asserted.
  assign in_idle   = (state_q == StIdle) && rst;
  assign mem_grant = in_idle && mem_req_valid;
  assign if_grant  = in_idle && if_req_valid && !mem_req_valid && !flush;

  assign mem_req_ready = mem_grant;
  assign if_req_ready  = if_grant;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    resp_data_d = resp_data_q;
    drop_d      = drop_q;

    // A flush poisons only a fetch; the bus side still runs to completion.
    if (flush && ((state_q == StIfReq) || (state_q == StIfWait) ||
                  ((state_q == StResp) && (owner_q == OWN_IF)))) begin
      drop_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (mem_grant) begin
          owner_d = OWN_MEM;
          wen_d   = mem_req_wen;
          addr_d  = mem_req_addr;
          wdata_d = mem_req_wdata;
          wstrb_d = mem_req_wen ? mem_req_wstrb : '0;
          state_d = StMemReq;
        end else if (if_grant) begin
          owner_d = OWN_IF;
          wen_d   = 1'b0;
          addr_d  = if_req_addr;
          wdata_d = '0;
          wstrb_d = '0;
          state_d = StIfReq;
        end
      end
      StIfReq, StMemReq: begin
        if (bus_req_ready) begin
          if (wen_q) begin
            resp_data_d = '0;
            state_d     = StResp;
          end else begin
            state_d = (state_q == StIfReq) ? StIfWait : StMemWait;
          end
        end
      end
      StIfWait, StMemWait: begin
        if (bus_rdata_valid) begin
          resp_data_d = bus_rdata;
          state_d     = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
        drop_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        drop_d  = 1'b0;
      end
    endcase

    // Registered outputs are derived from the next state so they line up
    // with the state they describe.
    bus_read_d        = is_req_state(state_d) && !wen_d;
    bus_write_d       = is_req_state(state_d) && wen_d;
    bus_rdata_ready_d = is_wait_state(state_d);
    if_resp_valid_d   = (state_d == StResp) && (owner_d == OWN_IF) && !drop_d;
    mem_resp_valid_d  = (state_d == StResp) && (owner_d == OWN_MEM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= StIdle;
      owner_q           <= OWN_IF;
      wen_q             <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      wstrb_q           <= '0;
      resp_data_q       <= '0;
      drop_q            <= 1'b0;
      bus_read_q        <= 1'b0;
      bus_write_q       <= 1'b0;
      bus_rdata_ready_q <= 1'b0;
      if_resp_valid_q   <= 1'b0;
      mem_resp_valid_q  <= 1'b0;
    end else begin
      state_q           <= state_d;
      owner_q           <= owner_d;
      wen_q             <= wen_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      wstrb_q           <= wstrb_d;
      resp_data_q       <= resp_data_d;
      drop_q            <= drop_d;
      bus_read_q        <= bus_read_d;
      bus_write_q       <= bus_write_d;
      bus_rdata_ready_q <= bus_rdata_ready_d;
      if_resp_valid_q   <= if_resp_valid_d;
      mem_resp_valid_q  <= mem_resp_valid_d;
    end
  end

  assign bus_addr        = addr_q;
  assign bus_wdata       = wdata_q;
  assign bus_wstrb       = wstrb_q;
  assign bus_read        = bus_read_q;
  assign bus_write       = bus_write_q;
  assign bus_rdata_ready = bus_rdata_ready_q;
  assign if_resp_valid   = if_resp_valid_q;
  assign mem_resp_valid  = mem_resp_valid_q;
  assign if_resp_data    = resp_data_q;
  assign mem_resp_data   = resp_data_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single shared memory port between the IF stage (instruction fetch, read-only) and the MEM stage (loads and stores) of the 5-stage RISC-V pipeline. It accepts at most one transaction at a time and registers its address and data. It drives the transaction onto the memory bus with valid/ready handshakes and routes the read response back to the requester. A pending fetch whose result is stale after a branch misprediction is discarded.

## Interface
Parameters:
- none; widths are fixed by `define.v` constants (address 32, data 32, strobe 4).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  IF requests a fetch.
- if_req_addr  in  32  fetch address.
- if_req_ready  out  1  fetch accepted this cycle.
- if_resp_valid  out  1  one-cycle pulse; fetched instruction on if_resp_data.
- if_resp_data  out  32  instruction word.
- mem_req_valid  in  1  MEM requests a load/store.
- mem_req_wen  in  1  1 = store, 0 = load.
- mem_req_addr  in  32  data address.
- mem_req_wdata  in  32  store data.
- mem_req_wstrb  in  4  byte enables for a store.
- mem_req_ready  out  1  load/store accepted this cycle.
- mem_resp_valid  out  1  one-cycle pulse: load data valid, or store completed.
- mem_resp_data  out  32  load data; 0 for a store.
- flush  in  1  branch misprediction (prediction_incorrect).
- bus_addr  out  32  memory address.
- bus_read  out  1  read request valid.
- bus_write  out  1  write request valid.
- bus_wdata  out  32  write data.
- bus_wstrb  out  4  write strobes.
- bus_req_ready  in  1  memory accepts the request.
- bus_rdata  in  32  read data.
- bus_rdata_valid  in  1  read data valid.
- bus_rdata_ready  out  1  arbiter accepts read data.

## Operation
- FSM states: IDLE, IF_REQ, IF_WAIT, MEM_REQ, MEM_WAIT, RESP.
- IDLE, arbitration:
  - Fixed priority; MEM wins because it is the older instruction.
  - mem_req_ready = mem_req_valid.
  - if_req_ready = if_req_valid & ~mem_req_valid & ~flush.
  - On a handshake, latch addr, wen, wdata and wstrb (wstrb forced to 0 for reads), then go to MEM_REQ or IF_REQ.
- IF_REQ / MEM_REQ:
  - Drive bus_read, or bus_write for a store, from the latched registers.
  - Hold the request until bus_req_ready.
  - On acceptance, a read goes to IF_WAIT or MEM_WAIT. A store goes to RESP with a store-done response.
- IF_WAIT / MEM_WAIT:
  - bus_rdata_ready = 1.
  - On bus_rdata_valid, capture bus_rdata into the response register and go to RESP.
- RESP:
  - Pulse the owner's resp_valid for exactly one cycle with the registered data, then go to IDLE.
  - Requesters must accept the response; there is no response backpressure.
- Flush:
  - drop flag set by flush while state ∈ {IF_REQ, IF_WAIT, RESP-for-IF}.
  - An IF request already on the bus is not withdrawn. It completes on the bus, but if_resp_valid is suppressed.
  - drop clears on the return to IDLE.
  - flush has no effect on MEM transactions.
- Only one outstanding transaction; no request is accepted outside IDLE.

## Timing
- Reset values (async, rst=0):
  - state IDLE, drop 0.
  - All *_ready, *_resp_valid, bus_read, bus_write and bus_rdata_ready are 0.
  - All data/address outputs are 0.
- Request ready signals are combinational from IDLE and the valid inputs.
- All bus outputs and response outputs are registered.
- Load with zero-wait memory:
  - cycle 0: accept.
  - cycle 1: bus_read and bus_req_ready.
  - cycle 2: bus_rdata_valid.
  - cycle 3: mem_resp_valid.
  - Latency 3 cycles; the next accept is possible in cycle 4.
- Store: accept at 0, bus handshake at 1, mem_resp_valid at 2.
- Simultaneous events:
  - Both requesters valid in IDLE: MEM is granted, IF waits.
  - flush in IDLE with if_req_valid: not accepted.
  - flush in the same cycle as bus_rdata_valid in IF_WAIT: response dropped.
- Reset mid-transaction returns to IDLE immediately. The bus transaction is abandoned; the memory side is reset by the same rst.

## Structure
- Add to `define.v`:
  - FSM state encodings (3-bit).
  - MEM_ARB_ADDR_W, MEM_ARB_DATA_W, MEM_ARB_STRB_W.
  - Owner codes OWN_IF / OWN_MEM.
- No sub-module is needed: a single FSM plus a request register and a response register. The priority grant is an inline expression.

## Test plan
- Load, zero-wait memory:
  - Stimulus: mem_req_valid with addr 0x100; bus returns 0xDEADBEEF.
  - Response: bus_read at cycle 1, mem_resp_valid with 0xDEADBEEF at cycle 3, if_resp_valid stays 0.
- Collision:
  - Stimulus: if_req_valid (0x0) and mem_req_valid (store 0x200, wdata 0x12345678, wstrb 0xF) in the same cycle.
  - Response: the store is issued first, with bus_write, bus_wdata 0x12345678 and bus_wstrb 0xF. The fetch is accepted only after mem_resp_valid.
- Stall:
  - Stimulus: bus_req_ready held low for 5 cycles during an IF fetch of 0x40.
  - Response: bus_addr stays 0x40 and bus_read stays high throughout; no new request is accepted.
- Flush:
  - Stimulus: flush asserted in IF_WAIT.
  - Response: bus_rdata is consumed (bus_rdata_ready=1) and no if_resp_valid follows. The next fetch returns correct data.
- Reset:
  - Stimulus: rst low during MEM_WAIT.
  - Response: all outputs are 0 asynchronously. After rst goes high, a new load completes normally.
